enc_dec_mux_unit: RTL and testbench

- Registered combinational-primitive cluster with three independent lanes sharing one clock and reset:
  - one-hot encoder;
  - binary-to-one-hot decoder;
  - N:1 bit multiplexer.
- Each lane produces a result plus an error flag. The flag marks an illegal input or selection.
- Used as a small utility/ALU-support block; the lanes do not interact.

---
 rtl/enc_dec_mux_unit.sv | 108 ++++++++++
 tb/tb_enc_dec_mux_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/enc_dec_mux_unit.sv
// Registered encoder / decoder / mux cluster. Three independent lanes, each
// producing a result and an illegal-input flag one cycle after its inputs.
module enc_dec_mux_unit #(
  parameter  int ENC_N = 4,
  parameter  int DEC_W = 2,
  parameter  int DEC_N = 4,
  parameter  int MUX_N = 4,
  localparam int ENC_W = (ENC_N > 1) ? $clog2(ENC_N) : 1,
  localparam int MUX_W = (MUX_N > 1) ? $clog2(MUX_N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ENC_N-1:0] enc_in,
  output logic [ENC_W-1:0] enc_out,
  output logic             enc_err,
  input  logic [DEC_W-1:0] dec_in,
  output logic [DEC_N-1:0] dec_out,
  output logic             dec_err,
  input  logic [MUX_N-1:0] mux_in,
  input  logic [MUX_W-1:0] mux_sel,
  output logic             mux_out,
  output logic             mux_err
);

  generate
    if (ENC_N < 1 || DEC_N < 1 || MUX_N < 1) begin : g_bad_size
      $error("enc_dec_mux_unit: ENC_N, DEC_N and MUX_N must all be at least 1");
    end
    if (DEC_N > (1 << DEC_W)) begin : g_bad_dec
      $error("enc_dec_mux_unit: DEC_N exceeds the range of a DEC_W-bit select");
    end
  endgenerate

  // One extra bit so the limit itself (up to 2^W) is representable.
  localparam logic [DEC_W:0] DEC_LIM = (DEC_W + 1)'(DEC_N);
  localparam logic [MUX_W:0] MUX_LIM = (MUX_W + 1)'(MUX_N);

  logic [ENC_W-1:0] enc_out_q, enc_out_d;
  logic             enc_err_q, enc_err_d;
  logic [DEC_N-1:0] dec_out_q, dec_out_d;
  logic             dec_err_q, dec_err_d;
  logic             mux_out_q, mux_out_d;
  logic             mux_err_q, mux_err_d;

  logic             enc_onehot;
  logic [ENC_W-1:0] enc_idx;
  logic             dec_legal;
  logic             mux_legal;
  logic [MUX_N-1:0] mux_hit;

  // Exactly one bit set; no priority resolution for multi-hot inputs.
  always_comb begin
    enc_onehot = (enc_in != '0) && ((enc_in & (enc_in - ENC_N'(1))) == '0);
    enc_idx    = '0;
    for (int i = 0; i < ENC_N; i++) begin
      if (enc_in[i]) enc_idx = enc_idx | ENC_W'(i);
    end
    enc_out_d = enc_onehot ? enc_idx : '0;
    enc_err_d = !enc_onehot;
  end

  assign dec_legal = ({1'b0, dec_in} < DEC_LIM);
  assign dec_err_d = !dec_legal;

  generate
    for (genvar gi = 0; gi < DEC_N; gi++) begin : g_dec
      assign dec_out_d[gi] = dec_legal && (dec_in == DEC_W'(gi));
    end
  endgenerate

  // AND-OR select keeps out-of-range selects at 0 without indexing past mux_in.
  assign mux_legal = ({1'b0, mux_sel} < MUX_LIM);
  assign mux_err_d = !mux_legal;

  generate
    for (genvar gi = 0; gi < MUX_N; gi++) begin : g_mux
      assign mux_hit[gi] = mux_in[gi] && (mux_sel == MUX_W'(gi));
    end
  endgenerate

  assign mux_out_d = |mux_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_out_q <= '0;
      enc_err_q <= 1'b0;
      dec_out_q <= '0;
      dec_err_q <= 1'b0;
      mux_out_q <= 1'b0;
      mux_err_q <= 1'b0;
    end else begin
      enc_out_q <= enc_out_d;
      enc_err_q <= enc_err_d;
      dec_out_q <= dec_out_d;
      dec_err_q <= dec_err_d;
      mux_out_q <= mux_out_d;
      mux_err_q <= mux_err_d;
    end
  end

  assign enc_out = enc_out_q;
  assign enc_err = enc_err_q;
  assign dec_out = dec_out_q;
  assign dec_err = dec_err_q;
  assign mux_out = mux_out_q;
  assign mux_err = mux_err_q;

endmodule

// File: tb/tb_enc_dec_mux_unit.sv
// Bench for enc_dec_mux_unit: a default instance plus one with DEC_N=3, MUX_N=3
// so out-of-range selects can be exercised; expected results flow through a queue.
module tb_enc_dec_mux_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance
  logic [3:0] enc_in;
  logic [1:0] enc_out;
  logic       enc_err;
  logic [1:0] dec_in;
  logic [3:0] dec_out;
  logic       dec_err;
  logic [3:0] mux_in;
  logic [1:0] mux_sel;
  logic       mux_out;
  logic       mux_err;

  // Non-power-of-two instance
  logic [3:0] enc3_in;
  logic [1:0] enc3_out;
  logic       enc3_err;
  logic [1:0] dec3_in;
  logic [2:0] dec3_out;
  logic       dec3_err;
  logic [2:0] mux3_in;
  logic [1:0] mux3_sel;
  logic       mux3_out;
  logic       mux3_err;

  enc_dec_mux_unit u_dut (
    .clk(clk), .rst(rst),
    .enc_in(enc_in), .enc_out(enc_out), .enc_err(enc_err),
    .dec_in(dec_in), .dec_out(dec_out), .dec_err(dec_err),
    .mux_in(mux_in), .mux_sel(mux_sel), .mux_out(mux_out), .mux_err(mux_err)
  );

  enc_dec_mux_unit #(.DEC_N(3), .MUX_N(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .enc_in(enc3_in), .enc_out(enc3_out), .enc_err(enc3_err),
    .dec_in(dec3_in), .dec_out(dec3_out), .dec_err(dec3_err),
    .mux_in(mux3_in), .mux_sel(mux3_sel), .mux_out(mux3_out), .mux_err(mux3_err)
  );

  typedef struct packed {
    logic [1:0] enc_out;
    logic       enc_err;
    logic [3:0] dec_out;
    logic       dec_err;
    logic       mux_out;
    logic       mux_err;
    logic [1:0] enc3_out;
    logic       enc3_err;
    logic [2:0] dec3_out;
    logic       dec3_err;
    logic       mux3_out;
    logic       mux3_err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  function automatic void model_enc(input logic [3:0] v, output logic [1:0] o, output logic e);
    o = 2'd0;
    e = 1'b1;
    if ($countones(v) == 1) begin
      e = 1'b0;
      for (int i = 0; i < 4; i++) if (v[i]) o = 2'(i);
    end
  endfunction

  function automatic exp_t model(input logic r);
    exp_t x;
    x = '0;
    if (!r) begin
      model_enc(enc_in, x.enc_out, x.enc_err);
      model_enc(enc3_in, x.enc3_out, x.enc3_err);
      x.dec_out  = 4'b0001 << dec_in;
      x.dec_err  = 1'b0;
      x.mux_out  = mux_in[mux_sel];
      x.mux_err  = 1'b0;
      if (dec3_in < 2'd3) x.dec3_out = 3'b001 << dec3_in;
      else                x.dec3_err = 1'b1;
      if (mux3_sel < 2'd3) x.mux3_out = mux3_in[mux3_sel];
      else                 x.mux3_err = 1'b1;
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Push the expectation for the current inputs, clock once, pop and compare.
  task automatic step();
    exp_t e;
    exp_q.push_back(model(rst));
    @(posedge clk);
    #1;
    cyc++;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty cycle %0d: observed 0 entries expected 1", cyc);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("enc_out",  32'(enc_out),  32'(e.enc_out));
      check("enc_err",  32'(enc_err),  32'(e.enc_err));
      check("dec_out",  32'(dec_out),  32'(e.dec_out));
      check("dec_err",  32'(dec_err),  32'(e.dec_err));
      check("mux_out",  32'(mux_out),  32'(e.mux_out));
      check("mux_err",  32'(mux_err),  32'(e.mux_err));
      check("enc3_out", 32'(enc3_out), 32'(e.enc3_out));
      check("enc3_err", 32'(enc3_err), 32'(e.enc3_err));
      check("dec3_out", 32'(dec3_out), 32'(e.dec3_out));
      check("dec3_err", 32'(dec3_err), 32'(e.dec3_err));
      check("mux3_out", 32'(mux3_out), 32'(e.mux3_out));
      check("mux3_err", 32'(mux3_err), 32'(e.mux3_err));
      $display("cycle %0d rst=%0b enc_in=%b dec_in=%b mux_in=%b sel=%b -> enc=%b/%b dec=%b/%b mux=%b/%b | dec3=%b/%b mux3=%b/%b",
               cyc, rst, enc_in, dec_in, mux_in, mux_sel, enc_out, enc_err, dec_out, dec_err,
               mux_out, mux_err, dec3_out, dec3_err, mux3_out, mux3_err);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with live inputs, then first normal edge
    rst = 1'b1;
    enc_in = 4'b0100; dec_in = 2'b10; mux_in = 4'b1010; mux_sel = 2'b01;
    enc3_in = 4'b0100; dec3_in = 2'b10; mux3_in = 3'b101; mux3_sel = 2'b00;
    step();
    step();
    rst = 1'b0;
    step();
    check("reset_release_enc_out", 32'(enc_out), 32'd2);
    check("reset_release_dec_out", 32'(dec_out), 32'b0100);
    check("reset_release_mux_out", 32'(mux_out), 32'd1);

    // Encoder sweep then error patterns
    enc_in = 4'b0001; step();
    enc_in = 4'b0010; step();
    enc_in = 4'b0100; step();
    enc_in = 4'b1000; step();
    check("enc_top_bit", 32'(enc_out), 32'd3);
    enc_in = 4'b0000; step();
    check("enc_zero_err", 32'(enc_err), 32'd1);
    enc_in = 4'b0110; step();
    check("enc_multi_err", 32'({enc_out, enc_err}), 32'b001);

    // Decoder / mux exhaustive on defaults
    mux_in = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      dec_in = 2'(i); mux_sel = 2'(i);
      step();
    end

    // Out-of-range selects on the 3-entry instance
    dec3_in = 2'b11; mux3_sel = 2'b11; mux3_in = 3'b111; step();
    check("dec3_oor", 32'({dec3_out, dec3_err}), 32'b0001);
    check("mux3_oor", 32'({mux3_out, mux3_err}), 32'b01);
    dec3_in = 2'b10; mux3_sel = 2'b10; step();
    check("dec3_top", 32'({dec3_out, dec3_err}), 32'b1000);
    check("mux3_top", 32'({mux3_out, mux3_err}), 32'b10);

    // Back-to-back random traffic
    for (int i = 0; i < 16; i++) begin
      enc_in   = 4'($urandom); dec_in   = 2'($urandom);
      mux_in   = 4'($urandom); mux_sel  = 2'($urandom);
      enc3_in  = 4'($urandom); dec3_in  = 2'($urandom);
      mux3_in  = 3'($urandom); mux3_sel = 2'($urandom);
      step();
    end

    // Reset mid-stream while an encoder error input is held
    enc_in = 4'b0011; enc3_in = 4'b0011; step();
    check("midstream_err_before", 32'(enc_err), 32'd1);
    rst = 1'b1; step();
    check("midstream_err_in_rst", 32'(enc_err), 32'd0);
    rst = 1'b0; step();
    check("midstream_err_after", 32'(enc_err), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
